// File: rtl/ctr_pkg.sv
// Shared definitions for the mod-N counter run controller: default counter
// width and the controller state encoding.
package ctr_pkg;

    localparam int unsigned CTR_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_PAUSED = 2'b10,
        ST_DONE   = 2'b11
    } ctr_state_e;

endpackage

// File: rtl/ctr_mod_n.sv
// Wrap-at-mod up-counter: counts 0..mod while enabled, synchronous clear,
// tc flags that the current value is the terminal value.
module ctr_mod_n
    import ctr_pkg::*;
#(
    parameter int unsigned WIDTH = CTR_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] mod,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear wins over enable; wrap to zero after the terminal value.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            if (count_q == mod) begin
                count_d = '0;
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tc    = (count_q == mod);

endmodule

// File: rtl/ctr_seq_ctrl.sv
// Run controller for a mod-N up-counter: latches modulus and repeat count at
// start, sequences the counter through the requested wraps, handles pause and
// abort, and pulses done when the run completes.
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  ST_IDLE   | waiting for start; counter held at 0
//  ST_RUN    | counter advancing; wraps counted toward reps_q
//  ST_PAUSED | counter and wrap count frozen until pause drops
//  ST_DONE   | one-cycle completion pulse, then back to idle
module ctr_seq_ctrl
    import ctr_pkg::*;
#(
    parameter int unsigned WIDTH = CTR_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             pause,
    input  logic [WIDTH-1:0] cfg_mod,
    input  logic [WIDTH-1:0] cfg_reps,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic [WIDTH-1:0] wrap_cnt,
    output logic             busy,
    output logic             done
);

    ctr_state_e       state_q;
    logic [WIDTH-1:0] mod_q;
    logic [WIDTH-1:0] reps_q;
    logic [WIDTH-1:0] wrap_q;
    logic             busy_q;
    logic             done_q;

    logic             adv;
    logic             cnt_clr;
    logic             cnt_tc;
    logic [WIDTH-1:0] wrap_inc;
    logic             last_wrap;

    // Counter control and wrap bookkeeping derived from the current state.
    always_comb begin
        adv       = (state_q == ST_RUN) && !pause && !abort;
        cnt_clr   = abort || (state_q == ST_IDLE) || (state_q == ST_DONE);
        wrap_inc  = wrap_q + WIDTH'(1);
        last_wrap = (reps_q != '0) && (wrap_inc == reps_q);
    end

    ctr_mod_n #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (adv),
        .mod   (mod_q),
        .count (count),
        .tc    (cnt_tc)
    );

    // Run sequencer: state, shadow config, wrap count and registered status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mod_q   <= '0;
            reps_q  <= '0;
            wrap_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                // wrap_q is left alone so software can see how far the run got
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            mod_q   <= cfg_mod;
                            reps_q  <= cfg_reps;
                            wrap_q  <= '0;
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (pause) begin
                            state_q <= ST_PAUSED;
                        end else if (cnt_tc) begin
                            wrap_q <= wrap_inc;
                            if (last_wrap) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    ST_PAUSED: begin
                        if (!pause) begin
                            state_q <= ST_RUN;
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tc       = adv && cnt_tc;
    assign wrap_cnt = wrap_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_ctr_seq_ctrl.sv
// Bench for ctr_seq_ctrl: directed scenarios followed by random traffic, with
// a run-level reference model feeding per-cycle and completion scoreboards.
module tb_ctr_seq_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         pause = 1'b0;
    logic [W-1:0] cfg_mod = '0;
    logic [W-1:0] cfg_reps = '0;
    logic [W-1:0] count;
    logic         tc;
    logic [W-1:0] wrap_cnt;
    logic         busy;
    logic         done;

    ctr_seq_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .pause    (pause),
        .cfg_mod  (cfg_mod),
        .cfg_reps (cfg_reps),
        .count    (count),
        .tc       (tc),
        .wrap_cnt (wrap_cnt),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int count;
        bit tc;
        bit busy;
        bit done;
        int wrap;
    } exp_t;

    typedef struct {
        int cyc;
        int wrap;
    } done_t;

    exp_t  exp_q[$];
    done_t done_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Run model: a run is described by how many counting edges it has seen.
    bit m_run, m_held, m_fin;
    int m_adv, m_mod, m_reps, m_start_cyc, m_stalls;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, expv, cyc);
        end
    endtask

    // Drive one cycle of inputs, record what the outputs must be in this
    // cycle, advance the model across the coming edge, then wait for it.
    task automatic step(input bit s, input bit a, input bit p, input bit r);
        exp_t  e;
        done_t d;
        start = s;
        abort = a;
        pause = p;
        rst   = r;
        e.count = (m_run || m_held) ? (m_adv % (m_mod + 1)) : 0;
        e.tc    = m_run && !p && !a && ((m_adv % (m_mod + 1)) == m_mod);
        e.busy  = m_run || m_held || m_fin;
        e.done  = m_fin;
        e.wrap  = (m_adv / (m_mod + 1)) % (1 << W);
        exp_q.push_back(e);
        if (r) begin
            m_run = 0; m_held = 0; m_fin = 0;
            m_adv = 0; m_mod = 0; m_reps = 0;
        end else if (a) begin
            m_run = 0; m_held = 0; m_fin = 0;
        end else if (m_fin) begin
            m_fin = 0;
        end else if (m_run) begin
            if (p) begin
                m_run = 0; m_held = 1; m_stalls++;
            end else begin
                m_adv++;
                if (m_reps != 0 && m_adv == (m_mod + 1) * m_reps) begin
                    m_run = 0; m_fin = 1;
                    d.cyc  = m_start_cyc + (m_mod + 1) * m_reps + 1 + m_stalls;
                    d.wrap = m_reps;
                    done_q.push_back(d);
                end
            end
        end else if (m_held) begin
            m_stalls++;
            if (!p) begin
                m_held = 0; m_run = 1;
            end
        end else if (s) begin
            m_mod = int'(cfg_mod); m_reps = int'(cfg_reps);
            m_adv = 0; m_stalls = 0; m_start_cyc = cyc;
            m_run = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0);
    endtask

    task automatic go(input int m, input int r);
        cfg_mod  = W'(m);
        cfg_reps = W'(r);
        step(1, 0, 0, 0);
    endtask

    // Monitor: compare every recorded cycle, and match done pulses to runs.
    always @(negedge clk) begin
        exp_t  e;
        done_t d;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("count", 32'(count), 32'(e.count));
            chk("tc", 32'(tc), 32'(e.tc));
            chk("busy", 32'(busy), 32'(e.busy));
            chk("done", 32'(done), 32'(e.done));
            chk("wrap_cnt", 32'(wrap_cnt), 32'(e.wrap));
            if (done === 1'b1) begin
                if (done_q.size() == 0) begin
                    chk("done_unexpected", 32'(1), 32'(0));
                end else begin
                    d = done_q.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(d.cyc));
                    chk("done_wrap", 32'(wrap_cnt), 32'(d.wrap));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        bit p_lvl;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        idle(2);

        go(15, 1);          idle(20);
        go(4, 3);           idle(18);

        go(9, 1);           idle(3);
        repeat (5) step(0, 0, 1, 0);
        idle(15);

        go(15, 2);          idle(7);
        step(0, 1, 0, 0);   idle(3);

        go(15, 1);          idle(5);
        step(0, 0, 0, 1);   idle(2);

        go(15, 1);          idle(3);
        cfg_mod = 4'd2;
        step(1, 0, 0, 0);   idle(20);

        go(0, 0);           idle(20);
        step(0, 1, 0, 0);   idle(2);

        go(5, 2);           idle(2);
        step(1, 1, 0, 0);   idle(3);

        p_lvl = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                cfg_mod  = W'($urandom_range(0, 7));
                cfg_reps = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom_range(1, 15));
            end
            if ($urandom_range(0, 9) == 0) p_lvl = !p_lvl;
            step($urandom_range(0, 5) == 0, $urandom_range(0, 59) == 0,
                 p_lvl, $urandom_range(0, 399) == 0);
        end
        step(0, 1, 0, 0);
        idle(3);

        chk("done_missing", 32'(done_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
